// File: rtl/life_support_monitor.sv
// rtl/life_support_monitor.sv - cabin condition classifier with persistence filter, latched alarm and defend/cool requests
module life_support_monitor #(
    parameter int N           = 5,
    parameter int TEMP_HI     = 24,
    parameter int TEMP_CRIT   = 28,
    parameter int SHIELD_LO   = 8,
    parameter int SHIELD_CRIT = 3,
    parameter int PERSIST     = 4
) (
    input  logic         clk,          // rising-edge clock
    input  logic         rst,          // synchronous, active-low reset
    input  logic         pwr,          // module power, 0 forces OFF
    input  logic [N-1:0] shield,       // shield level from counter
    input  logic [N-1:0] temp,         // temperature from counter
    input  logic         ack,          // crew alarm acknowledge
    output logic [1:0]   state,        // 00 OFF, 01 NOMINAL, 10 WARN, 11 CRITICAL
    output logic         alarm,        // latched crew alarm
    output logic         req_def,      // shield charge request (counter def)
    output logic         req_cool,     // thermal action request (counter sth)
    output logic [7:0]   crit_events   // saturating count of CRITICAL entries
);

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_NOM  = 2'b01;
    localparam logic [1:0] ST_WARN = 2'b10;
    localparam logic [1:0] ST_CRIT = 2'b11;

    localparam logic [N-1:0] TEMP_HI_V     = N'(TEMP_HI);
    localparam logic [N-1:0] TEMP_CRIT_V   = N'(TEMP_CRIT);
    localparam logic [N-1:0] SHIELD_LO_V   = N'(SHIELD_LO);
    localparam logic [N-1:0] SHIELD_CRIT_V = N'(SHIELD_CRIT);
    localparam logic [2:0]   PC_LAST       = 3'(PERSIST - 1);

    logic       warn_c;
    logic       crit_c;
    logic [2:0] pc;
    logic [2:0] pc_next;
    // In WARN, remembers which condition pc is counting: 1 = toward CRITICAL.
    logic       warn_dir;
    logic       warn_dir_next;
    logic [1:0] state_next;
    logic       alarm_next;
    logic       req_def_next;
    logic       req_cool_next;
    logic [7:0] crit_events_next;

    assign warn_c = (temp >= TEMP_HI_V) | (shield <= SHIELD_LO_V);
    assign crit_c = (temp >= TEMP_CRIT_V) | (shield <= SHIELD_CRIT_V);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_OFF;
            pc          <= 3'd0;
            warn_dir    <= 1'b0;
            alarm       <= 1'b0;
            req_def     <= 1'b0;
            req_cool    <= 1'b0;
            crit_events <= 8'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            warn_dir    <= warn_dir_next;
            alarm       <= alarm_next;
            req_def     <= req_def_next;
            req_cool    <= req_cool_next;
            crit_events <= crit_events_next;
        end
    end

    // Next-state logic with persistence filtering
    always_comb begin
        logic       cond;
        logic       dir_now;
        logic [1:0] target;
        logic [2:0] pc_eff;

        state_next    = state;
        pc_next       = pc;
        warn_dir_next = warn_dir;
        cond          = 1'b0;
        dir_now       = warn_dir;
        target        = state;
        pc_eff        = pc;

        if (!pwr) begin
            state_next = ST_OFF;
            pc_next    = 3'd0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_next = ST_NOM;
                    pc_next    = 3'd0;
                end
                ST_NOM: begin
                    cond   = warn_c;
                    target = ST_WARN;
                end
                ST_WARN: begin
                    // crit_c and ~warn_c are mutually exclusive; escalation is checked first.
                    if (crit_c) begin
                        cond    = 1'b1;
                        dir_now = 1'b1;
                        target  = ST_CRIT;
                    end else if (!warn_c) begin
                        cond    = 1'b1;
                        dir_now = 1'b0;
                        target  = ST_NOM;
                    end
                    // A direction flip makes this edge the first of a fresh run.
                    if (cond && (dir_now != warn_dir)) begin
                        pc_eff = 3'd0;
                    end
                    if (cond) begin
                        warn_dir_next = dir_now;
                    end
                end
                default: begin
                    cond   = !crit_c;
                    target = ST_WARN;
                end
            endcase

            if (state != ST_OFF) begin
                if (!cond) begin
                    pc_next = 3'd0;
                end else if (pc_eff >= PC_LAST) begin
                    state_next = target;
                    pc_next    = 3'd0;
                end else begin
                    pc_next = pc_eff + 3'd1;
                end
            end
        end
    end

    // Output logic (values registered on the next edge)
    always_comb begin
        logic enter_crit;
        logic enter_warn;

        enter_crit       = (state_next == ST_CRIT) && (state != ST_CRIT);
        enter_warn       = (state == ST_NOM) && (state_next == ST_WARN);
        alarm_next       = alarm;
        crit_events_next = crit_events;

        if (state_next == ST_OFF) begin
            alarm_next = 1'b0;
        end else if (enter_crit || enter_warn) begin
            alarm_next = 1'b1;
        end else if (ack && (state_next != ST_CRIT)) begin
            alarm_next = 1'b0;
        end

        if (enter_crit && (crit_events != 8'hFF)) begin
            crit_events_next = crit_events + 8'd1;
        end

        req_def_next  = (state_next != ST_OFF) && (shield <= SHIELD_LO_V);
        req_cool_next = (state_next != ST_OFF) && (temp >= TEMP_HI_V);
    end

endmodule

// File: tb/tb_life_support_monitor.sv
// tb/tb_life_support_monitor.sv - table-driven and randomized model checks for life_support_monitor
module tb_life_support_monitor;

    localparam int PERSIST = 4;

    logic       clk;
    logic       rst;
    logic       pwr;
    logic [4:0] shield;
    logic [4:0] temp;
    logic       ack;
    logic [1:0] state;
    logic       alarm;
    logic       req_def;
    logic       req_cool;
    logic [7:0] crit_events;

    int vectors;
    int miscompares;

    life_support_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .pwr         (pwr),
        .shield      (shield),
        .temp        (temp),
        .ack         (ack),
        .state       (state),
        .alarm       (alarm),
        .req_def     (req_def),
        .req_cool    (req_cool),
        .crit_events (crit_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       pwr;
        logic [4:0] shield;
        logic [4:0] temp;
        logic       ack;
        logic [1:0] e_state;
        logic       e_alarm;
        logic       e_def;
        logic       e_cool;
        logic [7:0] e_ce;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic p, input int s, input int t, input logic a,
                                input int es, input logic ea, input logic ed, input logic ec, input int ece);
        vec_t v;
        v.rst = r; v.pwr = p; v.shield = 5'(s); v.temp = 5'(t); v.ack = a;
        v.e_state = 2'(es); v.e_alarm = ea; v.e_def = ed; v.e_cool = ec; v.e_ce = 8'(ece);
        vecs.push_back(v);
    endfunction

    // Behavioural reference: tracks run lengths of each pending condition.
    int m_state, m_run_up, m_run_dn, m_ce;
    bit m_alarm, m_def, m_cool;

    task automatic model_step(input bit r, input bit p, input int s, input int t, input bit a);
        int nxt;
        bit w, c;
        w = (t >= 24) || (s <= 8);
        c = (t >= 28) || (s <= 3);
        if (!r) begin
            m_state = 0; m_run_up = 0; m_run_dn = 0; m_ce = 0;
            m_alarm = 0; m_def = 0; m_cool = 0;
        end else if (!p) begin
            m_state = 0; m_run_up = 0; m_run_dn = 0;
            m_alarm = 0; m_def = 0; m_cool = 0;
        end else begin
            nxt = m_state;
            case (m_state)
                0: nxt = 1;
                1: begin
                    m_run_up = w ? m_run_up + 1 : 0;
                    if (m_run_up == PERSIST) nxt = 2;
                end
                2: begin
                    m_run_up = c ? m_run_up + 1 : 0;
                    m_run_dn = !w ? m_run_dn + 1 : 0;
                    if (m_run_up == PERSIST) nxt = 3;
                    else if (m_run_dn == PERSIST) nxt = 1;
                end
                default: begin
                    m_run_dn = !c ? m_run_dn + 1 : 0;
                    if (m_run_dn == PERSIST) nxt = 2;
                end
            endcase
            if (nxt != m_state) begin
                m_run_up = 0;
                m_run_dn = 0;
            end
            if ((m_state == 1 && nxt == 2) || (nxt == 3 && m_state != 3)) m_alarm = 1;
            else if (a && (nxt == 1 || nxt == 2)) m_alarm = 0;
            if (nxt == 3 && m_state != 3 && m_ce < 255) m_ce++;
            m_def  = (s <= 8);
            m_cool = (t >= 24);
            m_state = nxt;
        end
    endtask

    task automatic drive_check(input logic r, input logic p, input logic [4:0] s, input logic [4:0] t,
                               input logic a, input logic [12:0] exp, input string name);
        logic [12:0] got;
        @(negedge clk);
        rst = r; pwr = p; shield = s; temp = t; ack = a;
        @(posedge clk);
        #1;
        got = {state, alarm, req_def, req_cool, crit_events};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got state=%0d alarm=%0d req_def=%0d req_cool=%0d crit_events=%0d, expected state=%0d alarm=%0d req_def=%0d req_cool=%0d crit_events=%0d",
                     name, got[12:11], got[10], got[9], got[8], got[7:0],
                     exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic model_drive(input bit r, input bit p, input int s, input int t, input bit a, input string name);
        model_step(r, p, s, t, a);
        drive_check(r, p, 5'(s), 5'(t), a, {2'(m_state), m_alarm, m_def, m_cool, 8'(m_ce)}, name);
    endtask

    initial begin
        int hold;
        int rs, rt;
        bit rr, rp;
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; pwr = 1'b1; shield = 5'd0; temp = 5'd31; ack = 1'b0;

        // reset
        add(0, 1, 0, 31, 0,   0, 0, 0, 0, 0);
        // escalation
        add(1, 1, 20, 10, 0,  1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 20, 25, 0,  1, 0, 0, 1, 0);
        add(1, 1, 20, 25, 0,  2, 1, 0, 1, 0);
        // WARN -> CRITICAL, ack ignored in CRITICAL
        for (int i = 0; i < 3; i++) add(1, 1, 2, 10, 0,  2, 1, 1, 0, 0);
        add(1, 1, 2, 10, 0,   3, 1, 1, 0, 1);
        add(1, 1, 2, 10, 1,   3, 1, 1, 0, 1);
        // de-escalate, alarm stays until acked
        for (int i = 0; i < 3; i++) add(1, 1, 20, 10, 0,  3, 1, 0, 0, 1);
        add(1, 1, 20, 10, 0,  2, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 20, 10, 0,  2, 1, 0, 0, 1);
        add(1, 1, 20, 10, 0,  1, 1, 0, 0, 1);
        add(1, 1, 20, 10, 1,  1, 0, 0, 0, 1);
        // glitch filter
        for (int i = 0; i < 3; i++) add(1, 1, 20, 25, 0,  1, 0, 0, 1, 1);
        add(1, 1, 20, 20, 0,  1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 20, 25, 0,  1, 0, 0, 1, 1);
        add(1, 1, 20, 25, 0,  2, 1, 0, 1, 1);
        // second CRITICAL entry, then power loss
        for (int i = 0; i < 3; i++) add(1, 1, 2, 10, 0,  2, 1, 1, 0, 1);
        add(1, 1, 2, 10, 0,   3, 1, 1, 0, 2);
        add(1, 0, 2, 10, 0,   0, 0, 0, 0, 2);
        add(1, 1, 2, 10, 0,   1, 0, 1, 0, 2);
        // reset mid-operation with pending count and ack
        add(1, 1, 20, 25, 0,  1, 0, 0, 1, 2);
        add(1, 1, 20, 25, 0,  1, 0, 0, 1, 2);
        add(0, 1, 20, 25, 1,  0, 0, 0, 0, 0);
        add(1, 1, 20, 25, 0,  1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 20, 25, 0,  1, 0, 0, 1, 0);
        // set and ack coincide: set wins; then ack clears in WARN
        add(1, 1, 20, 25, 1,  2, 1, 0, 1, 0);
        add(1, 1, 20, 25, 1,  2, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            drive_check(vecs[i].rst, vecs[i].pwr, vecs[i].shield, vecs[i].temp, vecs[i].ack,
                        {vecs[i].e_state, vecs[i].e_alarm, vecs[i].e_def, vecs[i].e_cool, vecs[i].e_ce},
                        $sformatf("vec%0d", i));
        end

        // crit_events saturation: cycle WARN <-> CRITICAL 260 times
        model_drive(0, 1, 20, 10, 0, "sat_reset");
        model_drive(1, 1, 20, 10, 0, "sat_on");
        for (int i = 0; i < PERSIST; i++) model_drive(1, 1, 6, 10, 0, "sat_warn");
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i < PERSIST; i++) model_drive(1, 1, 2, 10, 0, "sat_up");
            for (int i = 0; i < PERSIST; i++) model_drive(1, 1, 6, 10, 0, "sat_dn");
        end
        vectors++;
        if (crit_events !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_hold: got crit_events=%0d, expected 255", crit_events);
        end

        // randomized stimulus, inputs held for random run lengths
        model_drive(0, 1, 20, 10, 0, "rnd_reset");
        hold = 0; rs = 20; rt = 10; rr = 1; rp = 1;
        for (int n = 0; n < 4000; n++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 7);
                rs = $urandom_range(0, 31);
                rt = $urandom_range(0, 31);
                rp = ($urandom_range(0, 31) != 0);
            end
            hold--;
            rr = ($urandom_range(0, 99) != 0);
            model_drive(rr, rp, rs, rt, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/life_support_monitor.md
Name: life_support_monitor

Overview:
- Downstream consumer of the life-support saturation counter. Samples its shield and temperature outputs every cycle and classifies cabin condition as OFF, NOMINAL, WARN or CRITICAL, with persistence filtering.
- Drives a latched crew alarm with an acknowledge handshake.
- Returns registered defend/cool requests that feed the counter's def and sth inputs.

Parameters:
- N, 5, width of shield/temp inputs
- TEMP_HI, 24, warn threshold: warn when temp >= TEMP_HI
- TEMP_CRIT, 28, critical threshold: critical when temp >= TEMP_CRIT (must exceed TEMP_HI)
- SHIELD_LO, 8, warn threshold: warn when shield <= SHIELD_LO
- SHIELD_CRIT, 3, critical threshold: critical when shield <= SHIELD_CRIT (must be below SHIELD_LO)
- PERSIST, 4, consecutive qualifying edges needed for any state change; range 1..7

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous, active-low reset
- pwr  in  1  module power; 0 forces OFF
- shield  in  N  shield level from counter
- temp  in  N  temperature from counter
- ack  in  1  crew alarm acknowledge, sampled at the edge
- state  out  2  00 OFF, 01 NOMINAL, 10 WARN, 11 CRITICAL
- alarm  out  1  latched alarm
- req_def  out  1  request shield charge (to counter def)
- req_cool  out  1  request thermal action (to counter sth)
- crit_events  out  8  saturating count of entries into CRITICAL

Behaviour:
- All outputs are registered and update only on the rising edge of clk.
- Reset (rst=0 at an edge) has top priority. Values after reset: state=00, alarm=0, req_def=0, req_cool=0, crit_events=0, persistence counter=0. Reset mid-operation aborts any pending transition.
- Unsigned compares, evaluated combinationally on current inputs:
  - warn_c = (temp >= TEMP_HI) | (shield <= SHIELD_LO)
  - crit_c = (temp >= TEMP_CRIT) | (shield <= SHIELD_CRIT)
- pwr=0 (rst=1): next edge gives state=OFF, alarm=0, req_*=0, persistence counter=0. crit_events holds.
- OFF with pwr=1: NOMINAL at the next edge, with no persistence filtering.
- Persistence counter pc is 3 bits. Each state has one pending-condition c:
  - NOMINAL: c = warn_c
  - WARN: c = crit_c (escalate) or ~warn_c (de-escalate)
  - CRITICAL: c = ~crit_c
- Per edge in NOMINAL, WARN or CRITICAL:
  - c false: pc <= 0.
  - c true and pc < PERSIST-1: pc <= pc+1.
  - c true and pc == PERSIST-1: take the transition; pc <= 0.
  - Net effect: a transition fires on the PERSIST-th consecutive edge with c true.
- Transitions are single-step only:
  - NOMINAL->WARN
  - WARN->CRITICAL on crit_c, which takes precedence over ~warn_c
  - WARN->NOMINAL on ~warn_c
  - CRITICAL->WARN
  - No NOMINAL<->CRITICAL jump.
- In WARN, if the active condition switches between crit_c and ~warn_c, pc restarts at 0.
- alarm:
  - Set on the edge that enters WARN from NOMINAL, or enters CRITICAL.
  - Cleared on an edge with ack=1 when the resulting state is NOMINAL or WARN.
  - ack is ignored while the resulting state is CRITICAL.
  - If set and ack coincide, set wins.
  - Remains 1 through de-escalation until acked.
- req_def <= (state_next != OFF) & (shield <= SHIELD_LO). req_cool <= (state_next != OFF) & (temp >= TEMP_HI). No persistence filtering on either.
- crit_events increments by 1 on each edge whose transition enters CRITICAL, and holds at 255.

Test Plan (defaults):
- Reset: rst=0, pwr=1, temp=31, shield=0, ack=0, one edge -> state=00, alarm=0, req_def=0, req_cool=0, crit_events=0.
- Escalation: rst=1, pwr=1, temp=10, shield=20, one edge -> state=01. Then temp=25 -> after 3 edges state=01 and req_cool=1; 4th edge -> state=10, alarm=1.
- Glitch filter: from NOMINAL, temp=25 for 3 edges, temp=20 for 1 edge, temp=25 again -> state stays 01 until the 4th consecutive edge of the new run.
- Critical and ack: from WARN, shield=2 for 4 edges -> state=11, crit_events=1, req_def=1. Then ack=1 -> alarm stays 1. Then shield=20, temp=10 -> 4 edges to 10, 4 more edges to 01, alarm still 1. Then ack=1 one edge -> alarm=0.
- Power loss: in CRITICAL with crit_events=1, pwr=0 one edge -> state=00, alarm=0, req_*=0, crit_events=1. Then pwr=1 -> state=01 next edge.
- Reset mid-operation: in NOMINAL with pc=2 (temp=25) and ack=1, assert rst=0 one edge -> all reset values. Then release with temp=25 -> 1 edge to NOMINAL, then 4 edges to WARN.
